// File: rtl/usb_rx_decoder.sv
// USB receive-side decoder: SYNC detect, PID check, bit unstuffing, payload byte assembly.
// Define USB_RX_CRC_CHK_EN to build CRC5 (token) / CRC16 (data) residual checking.
module usb_rx_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_in,
  input  logic       bit_vld,
  input  logic       eop,
  output logic [1:0] pkt_type,
  output logic [3:0] pid,
  output logic [7:0] byte_out,
  output logic       byte_vld,
  output logic       pkt_done,
  output logic [2:0] err,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_PAYLOAD,
    ST_DRAIN
  } state_t;

  localparam logic [1:0] TYPE_TOKEN = 2'b01;
  localparam logic [1:0] TYPE_DATA  = 2'b11;

  state_t      state_q, state_d;
  logic [2:0]  sync_cnt_q, sync_cnt_d;
  logic [2:0]  ones_q, ones_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [3:0]  pid_q, pid_d;
  logic [1:0]  pkt_type_q, pkt_type_d;
  logic [7:0]  byte_out_q, byte_out_d;
  logic        byte_vld_q, byte_vld_d;
  logic        pkt_done_q, pkt_done_d;
  logic [2:0]  err_q, err_d;
`ifdef USB_RX_CRC_CHK_EN
  logic [4:0]  crc5_q, crc5_d;
  logic [15:0] crc16_q, crc16_d;
`endif

  logic [7:0]  shift_nxt;
  logic        stuff_slot;
  logic        pid_ok;
  logic [10:0] min_len;
  logic [10:0] max_len;

  assign shift_nxt  = {bit_in, shift_q[7:1]};
  assign stuff_slot = (ones_q == 3'd6);
  assign pid_ok     = (shift_nxt[7:4] == ~shift_nxt[3:0]) && (shift_nxt[1:0] != 2'b00);

  // Byte counts include the trailing CRC bytes.
  always_comb begin
    min_len = 11'd0;
    max_len = 11'd0;
    case (pkt_type_q)
      TYPE_TOKEN: begin
        min_len = 11'd2;
        max_len = 11'd2;
      end
      TYPE_DATA: begin
        min_len = 11'd2;
        max_len = 11'd1026;
      end
      default: begin
        min_len = 11'd0;
        max_len = 11'd0;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    ones_d     = ones_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    pid_d      = pid_q;
    pkt_type_d = pkt_type_q;
    byte_out_d = byte_out_q;
    byte_vld_d = 1'b0;
    pkt_done_d = 1'b0;
    err_d      = err_q;
`ifdef USB_RX_CRC_CHK_EN
    crc5_d     = crc5_q;
    crc16_d    = crc16_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bit_vld && !eop && !bit_in) begin
          state_d    = ST_SYNC;
          sync_cnt_d = 3'd1;
          err_d      = 3'b000;
        end
      end

      ST_SYNC: begin
        if (eop) begin
          state_d = ST_IDLE;
        end else if (bit_vld) begin
          if (sync_cnt_q == 3'd7) begin
            if (bit_in) begin
              state_d    = ST_PID;
              ones_d     = 3'd0;
              bit_cnt_d  = 3'd0;
              byte_cnt_d = 11'd0;
`ifdef USB_RX_CRC_CHK_EN
              crc5_d     = 5'h1F;
              crc16_d    = 16'hFFFF;
`endif
            end else begin
              state_d = ST_IDLE;
            end
          end else if (bit_in) begin
            state_d = ST_IDLE;
          end else begin
            sync_cnt_d = sync_cnt_q + 3'd1;
          end
        end
      end

      ST_PID: begin
        if (eop) begin
          state_d = ST_IDLE;
          if (bit_cnt_q != 3'd0) begin
            pkt_done_d = 1'b1;
            err_d[1]   = 1'b1;
          end
        end else if (bit_vld) begin
          if (stuff_slot) begin
            ones_d = 3'd0;
            if (bit_in) begin
              err_d[1] = 1'b1;
              state_d  = ST_DRAIN;
            end
          end else begin
            ones_d    = bit_in ? ones_q + 3'd1 : 3'd0;
            shift_d   = shift_nxt;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              pid_d      = shift_nxt[3:0];
              pkt_type_d = shift_nxt[1:0];
              if (pid_ok) begin
                state_d = ST_PAYLOAD;
              end else begin
                err_d[0] = 1'b1;
                state_d  = ST_DRAIN;
              end
            end
          end
        end
      end

      ST_PAYLOAD: begin
        if (eop) begin
          state_d    = ST_IDLE;
          pkt_done_d = 1'b1;
          if (bit_cnt_q != 3'd0 || byte_cnt_q < min_len) begin
            err_d[1] = 1'b1;
          end
`ifdef USB_RX_CRC_CHK_EN
          if (pkt_type_q == TYPE_TOKEN && crc5_q != 5'h0C) begin
            err_d[2] = 1'b1;
          end
          if (pkt_type_q == TYPE_DATA && crc16_q != 16'h800D) begin
            err_d[2] = 1'b1;
          end
`endif
        end else if (bit_vld) begin
          if (stuff_slot) begin
            ones_d = 3'd0;
            if (bit_in) begin
              err_d[1] = 1'b1;
              state_d  = ST_DRAIN;
            end
          end else begin
            ones_d    = bit_in ? ones_q + 3'd1 : 3'd0;
            shift_d   = shift_nxt;
            bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef USB_RX_CRC_CHK_EN
            crc5_d  = {crc5_q[3:0], 1'b0} ^ ((bit_in ^ crc5_q[4]) ? 5'h05 : 5'h00);
            crc16_d = {crc16_q[14:0], 1'b0} ^ ((bit_in ^ crc16_q[15]) ? 16'h8005 : 16'h0000);
`endif
            if (bit_cnt_q == 3'd7) begin
              // A byte beyond the type's maximum length is never forwarded.
              if (byte_cnt_q == max_len) begin
                err_d[1] = 1'b1;
                state_d  = ST_DRAIN;
              end else begin
                byte_vld_d = 1'b1;
                byte_out_d = shift_nxt;
                byte_cnt_d = byte_cnt_q + 11'd1;
              end
            end
          end
        end
      end

      ST_DRAIN: begin
        if (eop) begin
          state_d    = ST_IDLE;
          pkt_done_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sync_cnt_q <= 3'd0;
      ones_q     <= 3'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      byte_cnt_q <= 11'd0;
      pid_q      <= 4'h0;
      pkt_type_q <= 2'b00;
      byte_out_q <= 8'h00;
      byte_vld_q <= 1'b0;
      pkt_done_q <= 1'b0;
      err_q      <= 3'b000;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      ones_q     <= ones_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      pid_q      <= pid_d;
      pkt_type_q <= pkt_type_d;
      byte_out_q <= byte_out_d;
      byte_vld_q <= byte_vld_d;
      pkt_done_q <= pkt_done_d;
      err_q      <= err_d;
    end
  end

`ifdef USB_RX_CRC_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc5_q  <= 5'h1F;
      crc16_q <= 16'hFFFF;
    end else begin
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
    end
  end
`endif

  assign pkt_type = pkt_type_q;
  assign pid      = pid_q;
  assign byte_out = byte_out_q;
  assign byte_vld = byte_vld_q;
  assign pkt_done = pkt_done_q;
  assign err      = err_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: doc/usb_rx_decoder.md
USB_RX_DECODER -- requirements
Module: usb_rx_decoder

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge clock.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: bit_in  in  1  NRZI-decoded line bit, LSB-first.
REQ-004 SHALL have port: bit_vld  in  1  one-cycle strobe per bit time; bit_in sampled only when high.
REQ-005 SHALL have port: eop  in  1  one-cycle end-of-packet strobe (SE0 detected).
REQ-006 SHALL have port: pkt_type  out  2  01 token, 11 data, 10 handshake (same encoding as transmit-side stream select).
REQ-007 SHALL have port: pid  out  4  received PID nibble.
REQ-008 SHALL have port: byte_out  out  8  assembled payload byte.
REQ-009 SHALL have port: byte_vld  out  1  one-cycle pulse, byte_out valid.
REQ-010 SHALL have port: pkt_done  out  1  one-cycle pulse, packet ended; err valid.
REQ-011 SHALL have port: err  out  3  [0] PID check, [1] stuff/framing, [2] CRC.
REQ-012 SHALL have port: busy  out  1  high in any state except IDLE.

Function
REQ-013 SHALL implement states IDLE, SYNC, PID, PAYLOAD, DRAIN.
REQ-014 IDLE->SYNC on first bit_vld with bit_in=0; SYNC matches 0,0,0,0,0,0,0,1 (byte 0x80 LSB-first); mismatch -> IDLE.
REQ-015 SYNC->PID after final SYNC bit; PID->PAYLOAD after 8 unstuffed PID bits.
REQ-016 Bit unstuffing SHALL apply from first PID bit: after six consecutive 1s the next bit is discarded if 0; if 1, set err[1] and enter DRAIN.
REQ-017 Ones-run counter SHALL clear on any 0 bit and on entry to PID.
REQ-018 PID byte SHALL be valid when bits[7:4] == ~bits[3:0] and bits[1:0] != 00; otherwise set err[0], enter DRAIN.
REQ-019 pid and pkt_type SHALL update the cycle after the eighth PID bit and hold until next PID.
REQ-020 Payload bits shift into MSB of an 8-bit shifter; byte_vld SHALL pulse the cycle after the bit_vld completing each byte.
REQ-021 Length rules: handshake 0 bytes, token exactly 2, data 2..1026 (CRC bytes included and forwarded); violation sets err[1].
REQ-022 eop in PID (bits received), PAYLOAD or DRAIN SHALL pulse pkt_done next cycle and return to IDLE; partial byte at eop sets err[1].
REQ-023 eop in SYNC SHALL return to IDLE without pkt_done; eop in IDLE ignored.
REQ-024 Simultaneous bit_vld and eop: eop wins, bit discarded.
REQ-025 DRAIN SHALL suppress byte_vld and ignore bits until eop.
REQ-026 err SHALL be valid during pkt_done cycle and clear on next SYNC entry.

Reset
REQ-027 rst_n low SHALL force IDLE and all outputs to 0 immediately, including mid-packet.
REQ-028 After release, decoding SHALL begin only at a fresh SYNC.

Configuration
REQ-029 Macro USB_RX_CRC_CHK_EN defined: token payload checked with CRC5 (x^5+x^2+1, init 11111, residual 01100), data payload with CRC16 (x^16+x^15+x^2+1, init FFFF, residual 800D); mismatch sets err[2] at pkt_done.
REQ-030 Macro undefined: no CRC logic; err[2] constant 0.

Verification
REQ-031 SYNC, PID 0xD2, eop -> pkt_done, pkt_type=10, pid=2, err=000, no byte_vld.
REQ-032 SYNC, PID 0x69, bytes 0x00 0x10, eop -> byte_vld x2 (00,10), pkt_type=01, pid=9, err=000.
REQ-033 SYNC, PID 0xC3, bytes 0x00 0x00, eop -> two byte_vld, pkt_type=11, err=000.
REQ-034 SYNC, PID 0xC4 -> DRAIN, no byte_vld, err[0]=1 at pkt_done.
REQ-035 Data payload with seven consecutive 1s (no stuff bit) -> err[1]=1; rst_n pulse mid-payload -> all outputs 0, no pkt_done.
REQ-036 SYNC, PID 0xC3, bytes 0x00 0x01, eop -> err[2]=1 with USB_RX_CRC_CHK_EN, err=000 without.
